// File: rtl/rr_burst_scheduler.sv
// rr_burst_scheduler
//
// Round-robin scheduler that shares one downstream beat channel among N
// requesters. Each grant may last for a multi-beat burst. The grant ends on
// the owner's last beat, on a timeout after MAX_BEATS beats, or when the
// owner drops its request (abort). The priority pointer then moves past the
// owner.
//
// Ports:
//   clk       - clock; all state updates on the rising edge
//   rst       - asynchronous active-high reset
//   req       - per-requester request, held for the whole burst
//   last      - per-requester last-beat flag (only the owner's bit is used)
//   rdy       - downstream accepts a beat this cycle
//   gnt       - registered one-hot grant, or all zero
//   gnt_valid - |gnt
//   gnt_idx   - owner index (meaningful while gnt_valid is high)
//   fire      - combinational: one beat accepted this cycle
//   ptr       - current highest-priority index
//   beat_cnt  - beats accepted in the current grant
module rr_burst_scheduler #(
    parameter int N         = 8,
    parameter int MAX_BEATS = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N-1:0]                   req,
    input  logic [N-1:0]                   last,
    input  logic                           rdy,
    output logic [N-1:0]                   gnt,
    output logic                           gnt_valid,
    output logic [$clog2(N)-1:0]           gnt_idx,
    output logic                           fire,
    output logic [$clog2(N)-1:0]           ptr,
    output logic [$clog2(MAX_BEATS+1)-1:0] beat_cnt
);

    localparam int          IW = $clog2(N);
    localparam int          CW = $clog2(MAX_BEATS + 1);
    localparam int unsigned NU = N;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            sel_found;
    logic [IW-1:0]   sel_idx;
    logic            owner_req;
    logic            end_beat;

    // Modulo-N add. The result never reaches N, even when N is not a
    // power of 2.
    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base,
                                               input int unsigned   step);
        int unsigned s;
        s = 32'(base) + step;
        if (s >= NU) s = s - NU;
        return IW'(s);
    endfunction

    // Search for the first requester at or above ptr, wrapping around.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int unsigned i = 0; i < NU; i++) begin
            if (!sel_found && req[wrap_add(ptr_q, i)]) begin
                sel_found = 1'b1;
                sel_idx   = wrap_add(ptr_q, i);
            end
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = |gnt_q;
    assign gnt_idx   = idx_q;
    assign ptr       = ptr_q;
    assign beat_cnt  = cnt_q;

    assign owner_req = req[idx_q];
    assign fire      = gnt_valid & owner_req & rdy;
    // A normal end and a timeout on the same beat give a single release.
    assign end_beat  = fire & (last[idx_q] | (cnt_q == CW'(MAX_BEATS - 1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    state_d        = BUSY;
                    gnt_d          = '0;
                    gnt_d[sel_idx] = 1'b1;
                    idx_d          = sel_idx;
                    cnt_d          = '0;
                end
            end
            BUSY: begin
                // An abort has priority. When req drops, fire is 0, so no
                // beat is counted.
                if (!owner_req || end_beat) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    cnt_d   = '0;
                    ptr_d   = wrap_add(idx_q, 1);
                end else if (fire) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_rr_burst_scheduler.sv
module tb_rr_burst_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic chk_en = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    // Instance a: N=8, MAX_BEATS=16
    logic [7:0] a_req, a_last, a_gnt;
    logic       a_rdy, a_gv, a_fire;
    logic [2:0] a_gi, a_ptr;
    logic [4:0] a_cnt;
    // Instance t: N=8, MAX_BEATS=4 (timeout)
    logic [7:0] t_req, t_last, t_gnt;
    logic       t_rdy, t_gv, t_fire;
    logic [2:0] t_gi, t_ptr;
    logic [2:0] t_cnt;
    // Instance w: N=5, MAX_BEATS=16 (non power of 2)
    logic [4:0] w_req, w_last, w_gnt;
    logic       w_rdy, w_gv, w_fire;
    logic [2:0] w_gi, w_ptr;
    logic [4:0] w_cnt;

    rr_burst_scheduler #(.N(8), .MAX_BEATS(16)) u_a (
        .clk(clk), .rst(rst), .req(a_req), .last(a_last), .rdy(a_rdy),
        .gnt(a_gnt), .gnt_valid(a_gv), .gnt_idx(a_gi), .fire(a_fire),
        .ptr(a_ptr), .beat_cnt(a_cnt));

    rr_burst_scheduler #(.N(8), .MAX_BEATS(4)) u_t (
        .clk(clk), .rst(rst), .req(t_req), .last(t_last), .rdy(t_rdy),
        .gnt(t_gnt), .gnt_valid(t_gv), .gnt_idx(t_gi), .fire(t_fire),
        .ptr(t_ptr), .beat_cnt(t_cnt));

    rr_burst_scheduler #(.N(5), .MAX_BEATS(16)) u_w (
        .clk(clk), .rst(rst), .req(w_req), .last(w_last), .rdy(w_rdy),
        .gnt(w_gnt), .gnt_valid(w_gv), .gnt_idx(w_gi), .fire(w_fire),
        .ptr(w_ptr), .beat_cnt(w_cnt));

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Abstract model: who owns the channel, where the pointer is, and how
    // many beats have been taken.
    typedef struct {
        bit busy;
        int owner;
        int ptr;
        int cnt;
    } mstate_t;

    mstate_t ma = '{0, 0, 0, 0};
    mstate_t mt = '{0, 0, 0, 0};
    mstate_t mw = '{0, 0, 0, 0};

    function automatic mstate_t mstep(mstate_t s, int n, int maxb,
                                      logic [7:0] rq, logic [7:0] ls, logic rd);
        mstate_t r = s;
        bit found = 0;
        if (!s.busy) begin
            for (int k = 0; k < n; k++) begin
                int j = (s.ptr + k) % n;
                if (!found && rq[j]) begin
                    found   = 1;
                    r.busy  = 1;
                    r.owner = j;
                    r.cnt   = 0;
                end
            end
        end else if (!rq[s.owner] || (rd && (ls[s.owner] || s.cnt + 1 == maxb))) begin
            r.busy = 0;
            r.ptr  = (s.owner + 1) % n;
            r.cnt  = 0;
        end else if (rd) begin
            r.cnt = s.cnt + 1;
        end
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ma <= '{0, 0, 0, 0};
            mt <= '{0, 0, 0, 0};
            mw <= '{0, 0, 0, 0};
        end else begin
            ma <= mstep(ma, 8, 16, a_req, a_last, a_rdy);
            mt <= mstep(mt, 8, 4, t_req, t_last, t_rdy);
            mw <= mstep(mw, 5, 16, {3'b0, w_req}, {3'b0, w_last}, w_rdy);
        end
    end

    task automatic cmp(input string tag, input mstate_t m, input logic [7:0] rq,
                       input logic rd, input logic [7:0] g, input logic gv,
                       input logic [2:0] gi, input logic f, input logic [2:0] p,
                       input logic [4:0] bc);
        logic [7:0] eg;
        logic       ef;
        eg = m.busy ? (8'd1 << m.owner) : 8'd0;
        ef = m.busy && rq[m.owner] && rd;
        check({tag, ".gnt"},       32'(g),  32'(eg));
        check({tag, ".gnt_valid"}, 32'(gv), 32'(m.busy));
        if (m.busy) check({tag, ".gnt_idx"}, 32'(gi), 32'(m.owner));
        check({tag, ".fire"},      32'(f),  32'(ef));
        check({tag, ".ptr"},       32'(p),  32'(m.ptr));
        check({tag, ".beat_cnt"},  32'(bc), 32'(m.cnt));
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("a", ma, a_req, a_rdy, a_gnt, a_gv, a_gi, a_fire, a_ptr, a_cnt);
            cmp("t", mt, t_req, t_rdy, t_gnt, t_gv, t_gi, t_fire, t_ptr, {2'b0, t_cnt});
            cmp("w", mw, {3'b0, w_req}, w_rdy, {3'b0, w_gnt}, w_gv, w_gi, w_fire, w_ptr, w_cnt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [7:0] e;
        a_req = '0; a_last = '0; a_rdy = 1'b0;
        t_req = '0; t_last = '0; t_rdy = 1'b0;
        w_req = '0; w_last = '0; w_rdy = 1'b0;
        rst = 1'b1;
        #1 chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check("rst_gnt", 32'(a_gnt), 32'h0);
        check("rst_gv",  32'(a_gv),  32'h0);
        check("rst_gi",  32'(a_gi),  32'h0);
        check("rst_ptr", 32'(a_ptr), 32'h0);

        // Rotation with all requesters active and single-beat bursts
        a_req = 8'hFF; a_last = 8'hFF; a_rdy = 1'b0;
        rst = 1'b0;
        tick(); check("first_gnt", 32'(a_gnt), 32'h01);
        a_rdy = 1'b1;
        tick(); check("first_rel_gnt", 32'(a_gnt), 32'h0);
        check("first_rel_ptr", 32'(a_ptr), 32'h1);
        for (int k = 1; k <= 8; k++) begin
            e = 8'd1 << (k % 8);
            tick(); check("rot_gnt", 32'(a_gnt), 32'(e));
            tick(); check("rot_ptr", 32'(a_ptr), 32'((k + 1) % 8));
        end
        a_req = '0; a_last = '0; a_rdy = 1'b0;
        tick();

        // Burst hold: requester 3, four beats with rdy alternating
        a_req = 8'h08;
        tick(); check("hold_gnt0", 32'(a_gnt), 32'h08);
        for (int c = 0; c < 8; c++) begin
            a_rdy  = (c % 2 == 1);
            a_last = (c == 7) ? 8'h08 : 8'h00;
            #1;
            check("hold_gnt",  32'(a_gnt), 32'h08);
            check("hold_cnt",  32'(a_cnt), 32'(c / 2));
            check("hold_fire", 32'(a_fire), 32'(c % 2));
            tick();
        end
        check("hold_rel_gnt", 32'(a_gnt), 32'h0);
        check("hold_rel_ptr", 32'(a_ptr), 32'h4);
        check("hold_rel_cnt", 32'(a_cnt), 32'h0);
        a_req = '0; a_last = '0; a_rdy = 1'b0;
        tick();

        // Abort: requester 2 drops after 2 beats while 6 waits
        a_req = 8'h04;
        tick(); check("abort_gnt", 32'(a_gnt), 32'h04);
        a_req = 8'h44; a_last = 8'h40; a_rdy = 1'b1;
        tick(); tick();
        check("abort_cnt2", 32'(a_cnt), 32'h2);
        check("abort_gnt2", 32'(a_gnt), 32'h04);
        a_req = 8'h40;
        #1 check("abort_fire", 32'(a_fire), 32'h0);
        tick();
        check("abort_rel_gnt", 32'(a_gnt), 32'h0);
        check("abort_rel_ptr", 32'(a_ptr), 32'h3);
        check("abort_rel_cnt", 32'(a_cnt), 32'h0);
        tick(); check("abort_next_gnt", 32'(a_gnt), 32'h40);
        tick(); check("abort_next_ptr", 32'(a_ptr), 32'h7);
        a_req = '0; a_last = '0; a_rdy = 1'b0;
        tick();

        // Timeout: MAX_BEATS=4, requester 5 never asserts last
        t_req = 8'h20; t_last = '0; t_rdy = 1'b1;
        tick(); check("to_gnt", 32'(t_gnt), 32'h20);
        for (int f = 0; f < 4; f++) begin
            check("to_cnt", 32'(t_cnt), 32'(f));
            check("to_hold", 32'(t_gnt), 32'h20);
            tick();
        end
        check("to_rel_gnt", 32'(t_gnt), 32'h0);
        check("to_rel_ptr", 32'(t_ptr), 32'h6);
        check("to_rel_cnt", 32'(t_cnt), 32'h0);
        t_req = '0; t_rdy = 1'b0;
        tick();

        // Wrap and skip with N=5
        w_req = 5'b01000; w_last = 5'b01000; w_rdy = 1'b1;
        tick(); check("w_pre_gnt", 32'(w_gnt), 32'h08);
        tick(); check("w_pre_ptr", 32'(w_ptr), 32'h4);
        w_req = 5'b00110; w_last = '0;
        tick(); check("w_gnt1", 32'(w_gnt), 32'h02);
        check("w_idx1", 32'(w_gi), 32'h1);
        w_last = 5'b00010;
        tick(); check("w_ptr2", 32'(w_ptr), 32'h2);
        check("w_rel_gnt", 32'(w_gnt), 32'h0);
        tick(); check("w_gnt2", 32'(w_gnt), 32'h04);
        w_last = 5'b00100;
        tick(); check("w_ptr3", 32'(w_ptr), 32'h3);
        w_req = '0; w_last = '0; w_rdy = 1'b0;
        tick();

        // Asynchronous reset during a burst
        a_req = 8'h10; a_rdy = 1'b0;
        tick(); check("ar_gnt", 32'(a_gnt), 32'h10);
        a_rdy = 1'b1;
        tick(); check("ar_cnt", 32'(a_cnt), 32'h1);
        #1 rst = 1'b1;
        #1;
        check("ar_rst_gnt",  32'(a_gnt),  32'h0);
        check("ar_rst_gv",   32'(a_gv),   32'h0);
        check("ar_rst_fire", 32'(a_fire), 32'h0);
        check("ar_rst_ptr",  32'(a_ptr),  32'h0);
        check("ar_rst_cnt",  32'(a_cnt),  32'h0);
        rst = 1'b0;
        tick(); check("ar_regrant", 32'(a_gnt), 32'h10);
        a_req = '0; a_rdy = 1'b0;
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
